// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, writeback source ids and result record
//
// Purpose:
//   Common definitions for the i2o2 writeback path. This file holds the
//   architectural widths, the source-id encoding used by the writeback
//   arbiter, and the packed result record that the completion FIFOs carry.
//
// Contents:
//   XLEN, REGW      data width and register index width
//   wb_src_e        writeback source id (SRC_AM / SRC_MEM)
//   wb_result_t     {rd, data} record stored per completion FIFO entry
//   WB_RESULT_W     bit width of wb_result_t
//   writes_regfile  true when a result targets a real register (rd != x0)

package core_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic {
    SRC_AM  = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_result_t;

  localparam int WB_RESULT_W = $bits(wb_result_t);

  // x0 is hardwired to zero and is never marked pending, so results aimed
  // at it are retired silently.
  function automatic logic writes_regfile(input wb_result_t r);
    return r.rd != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small circular completion FIFO for one writeback source
//
// Purpose:
//   Holds up to DEPTH completed results from one execution source until the
//   writeback arbiter retires them. Read/write pointers wrap naturally at
//   DEPTH (a power of two); occupancy is tracked in a registered count so
//   that full/empty never depend combinationally on push/pop.
//
// Ports:
//   clock      in   core clock, rising edge
//   reset      in   asynchronous active-low reset, empties the FIFO
//   push       in   enqueue push_data (ignored while full)
//   push_data  in   WIDTH-bit entry to enqueue
//   pop        in   dequeue the head entry (ignored while empty)
//   head       out  current head entry, valid while !empty
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupancy 0..DEPTH

module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = WB_RESULT_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = store_q[rd_ptr_q];

  // Guards keep the pointers coherent even if a caller ignores full/empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clock) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter onto the single register-file port
//
// Purpose:
//   Writeback stage of the i2o2 core. ALUMISC and memory results each land
//   in their own completion FIFO; each cycle one head is chosen and written
//   through registered outputs to the register file, together with the
//   release of the issue-stage scoreboard pending bit. Memory results win
//   by default; after STARVE_LIMIT consecutive lost arbitrations the ALU
//   head is taken instead so ALU results always make progress.
//
// Ports:
//   clock         in   core clock, rising edge
//   reset         in   asynchronous active-low reset, discards queued results
//   am_wb_valid   in   ALUMISC result valid
//   am_wb_rd      in   ALUMISC destination register
//   am_wb_data    in   ALUMISC result value
//   am_wb_ready   out  ALU FIFO can accept (registered, no path from valid)
//   mem_wb_valid  in   memory result valid
//   mem_wb_rd     in   memory destination register
//   mem_wb_data   in   load data
//   mem_wb_ready  out  memory FIFO can accept (registered, no path from valid)
//   wb_we         out  register-file write enable, one cycle per write
//   wb_rd         out  register-file write index
//   wb_data       out  register-file write data
//   wb_release    out  clear scoreboard pending bit of wb_rd (equals wb_we)

module wb_arbiter
  import core_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            am_wb_valid,
  input  logic [REGW-1:0] am_wb_rd,
  input  logic [XLEN-1:0] am_wb_data,
  output logic            am_wb_ready,
  input  logic            mem_wb_valid,
  input  logic [REGW-1:0] mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            mem_wb_ready,
  output logic            wb_we,
  output logic [REGW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_release
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Accept enable is low through reset and rises on the first edge after
  // release, so both sources see ready=0 while reset is held.
  logic            accept_en_q;
  logic [SW-1:0]   starve_q;

  wb_result_t      am_in;
  wb_result_t      mem_in;
  wb_result_t      am_head;
  wb_result_t      mem_head;
  wb_result_t      winner;
  wb_src_e         winner_src;

  logic            am_push;
  logic            mem_push;
  logic            am_pop;
  logic            mem_pop;
  logic            do_pop;
  logic            am_full;
  logic            am_empty;
  logic            mem_full;
  logic            mem_empty;
  logic [CW-1:0]   am_count;
  logic [CW-1:0]   mem_count;

  // ---------------------------------------------------------------------
  // Source handshakes
  // ---------------------------------------------------------------------
  assign am_wb_ready  = accept_en_q && !am_full;
  assign mem_wb_ready = accept_en_q && !mem_full;

  assign am_push      = am_wb_valid && am_wb_ready;
  assign mem_push     = mem_wb_valid && mem_wb_ready;

  assign am_in        = '{rd: am_wb_rd, data: am_wb_data};
  assign mem_in       = '{rd: mem_wb_rd, data: mem_wb_data};

  // ---------------------------------------------------------------------
  // Completion FIFOs, one per source
  // ---------------------------------------------------------------------
  wb_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (WB_RESULT_W)
  ) u_am_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (am_push),
    .push_data (am_in),
    .pop       (am_pop),
    .head      (am_head),
    .full      (am_full),
    .empty     (am_empty),
    .count     (am_count)
  );

  wb_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (WB_RESULT_W)
  ) u_mem_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (mem_push),
    .push_data (mem_in),
    .pop       (mem_pop),
    .head      (mem_head),
    .full      (mem_full),
    .empty     (mem_empty),
    .count     (mem_count)
  );

  // ---------------------------------------------------------------------
  // Arbitration on the FIFO heads
  // ---------------------------------------------------------------------
  // The ALU takes the port when it is alone, or when it has already lost
  // STARVE_LIMIT arbitrations in a row; otherwise a waiting memory result
  // goes first.
  always_comb begin
    am_pop     = 1'b0;
    mem_pop    = 1'b0;
    winner_src = SRC_MEM;
    if (!am_empty && (mem_empty || starve_q == STARVE_MAX)) begin
      am_pop     = 1'b1;
      winner_src = SRC_AM;
    end else if (!mem_empty) begin
      mem_pop    = 1'b1;
      winner_src = SRC_MEM;
    end
  end

  assign do_pop = am_pop || mem_pop;
  assign winner = (winner_src == SRC_AM) ? am_head : mem_head;

  // ---------------------------------------------------------------------
  // Starvation counter and registered write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_en_q <= 1'b0;
      starve_q    <= '0;
      wb_we       <= 1'b0;
      wb_release  <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      accept_en_q <= 1'b1;

      // Counts only consecutive losses while an ALU result is waiting.
      if (!am_empty && !am_pop) begin
        if (starve_q != STARVE_MAX) begin
          starve_q <= starve_q + SW'(1);
        end
      end else begin
        starve_q <= '0;
      end

      // Popped x0 results retire with no write and no release.
      wb_we      <= do_pop && writes_regfile(winner);
      wb_release <= do_pop && writes_regfile(winner);
      if (do_pop) begin
        wb_rd   <= winner.rd;
        wb_data <= winner.data;
      end
    end
  end

  // Occupancy can never exceed the FIFO depth.
  am_count_in_range: assert property (
    @(posedge clock) disable iff (!reset) am_count <= CW'(DEPTH)
  );
  mem_count_in_range: assert property (
    @(posedge clock) disable iff (!reset) mem_count <= CW'(DEPTH)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for the writeback arbiter

module tb_wb_arbiter;
  import core_pkg::*;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 3;

  logic            clk;
  logic            reset;
  logic            am_wb_valid;
  logic [REGW-1:0] am_wb_rd;
  logic [XLEN-1:0] am_wb_data;
  logic            am_wb_ready;
  logic            mem_wb_valid;
  logic [REGW-1:0] mem_wb_rd;
  logic [XLEN-1:0] mem_wb_data;
  logic            mem_wb_ready;
  logic            wb_we;
  logic [REGW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_release;

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .am_wb_valid  (am_wb_valid),
    .am_wb_rd     (am_wb_rd),
    .am_wb_data   (am_wb_data),
    .am_wb_ready  (am_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_rd    (mem_wb_rd),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_release   (wb_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: per-source queues of pending results, a loss counter,
  // and the write-port values expected after each rising edge.
  wb_result_t am_q[$];
  wb_result_t mem_q[$];
  int         m_starve;
  bit         m_alive;
  bit         m_we;
  logic [4:0] m_rd;
  logic [31:0] m_data;

  function automatic void model_clear();
    am_q.delete();
    mem_q.delete();
    m_starve = 0;
    m_alive  = 1'b0;
    m_we     = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endfunction

  function automatic void model_edge();
    bit am_rdy;
    bit mem_rdy;
    bit am_waiting;
    bit take_am;
    bit take_mem;
    wb_result_t w;
    am_rdy     = m_alive && (am_q.size() < DEPTH);
    mem_rdy    = m_alive && (mem_q.size() < DEPTH);
    am_waiting = am_q.size() > 0;
    take_am    = am_waiting && (mem_q.size() == 0 || m_starve == STARVE_LIMIT);
    take_mem   = !take_am && mem_q.size() > 0;
    m_we       = 1'b0;
    if (take_am || take_mem) begin
      if (take_am) w = am_q.pop_front();
      else         w = mem_q.pop_front();
      m_we   = (w.rd != 0);
      m_rd   = w.rd;
      m_data = w.data;
    end
    if (am_waiting && !take_am) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
    else                        m_starve = 0;
    if (am_wb_valid && am_rdy)   am_q.push_back('{rd: am_wb_rd, data: am_wb_data});
    if (mem_wb_valid && mem_rdy) mem_q.push_back('{rd: mem_wb_rd, data: mem_wb_data});
    m_alive = 1'b1;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_we"},        32'(wb_we),        32'(m_we));
    check({tag, "_release"},   32'(wb_release),   32'(m_we));
    check({tag, "_am_ready"},  32'(am_wb_ready),  32'(m_alive && am_q.size() < DEPTH));
    check({tag, "_mem_ready"}, 32'(mem_wb_ready), 32'(m_alive && mem_q.size() < DEPTH));
    if (m_we) begin
      check({tag, "_rd"},   32'(wb_rd), 32'(m_rd));
      check({tag, "_data"}, wb_data,    m_data);
    end
  endtask

  // Called in the low phase: predicts the next edge, steps past it, compares.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    am_wb_valid  = 1'b0;
    am_wb_rd     = '0;
    am_wb_data   = '0;
    mem_wb_valid = 1'b0;
    mem_wb_rd    = '0;
    mem_wb_data  = '0;
  endtask

  // Entered at a falling edge: 2 ns low pulse, checks while low and after.
  task automatic apply_reset(input string tag);
    idle_inputs();
    #1 reset = 1'b0;
    #1;
    check({tag, "_rst_we"},        32'(wb_we),        32'd0);
    check({tag, "_rst_release"},   32'(wb_release),   32'd0);
    check({tag, "_rst_rd"},        32'(wb_rd),        32'd0);
    check({tag, "_rst_data"},      wb_data,           32'd0);
    check({tag, "_rst_am_ready"},  32'(am_wb_ready),  32'd0);
    check({tag, "_rst_mem_ready"}, 32'(mem_wb_ready), 32'd0);
    #1 reset = 1'b1;
    model_clear();
    cycle({tag, "_post_rst"});
  endtask

  typedef struct {
    logic        am_v;
    logic [4:0]  am_rd;
    logic [31:0] am_d;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_d;
    logic        exp_we;
    logic        chk_rd;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic ew, input logic cr, input logic [4:0] er,
                              input logic [31:0] ed);
    vec_t v;
    v.am_v = av;  v.am_rd = ar;  v.am_d = ad;
    v.mem_v = mv; v.mem_rd = mr; v.mem_d = md;
    v.exp_we = ew; v.chk_rd = cr; v.exp_rd = er; v.exp_data = ed;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int am_idx;
    int mseq;
    int first_alu_edge;
    int late_we;
    bit saw_stall;
    bit am_acc;
    bit mem_acc;
    int am_order[$];

    reset = 1'b1;
    idle_inputs();
    model_clear();
    #1 reset = 1'b0;
    @(negedge clk);

    // ---------------- reset behaviour ----------------
    apply_reset("init");

    // ---------------- table-driven directed vectors ----------------
    // Each row: inputs applied for one edge, then the write port after it.
    vecs[0] = mk(1, 10, 32'd7,      0,  0, 32'h0,      0, 0,  0, 32'h0);
    vecs[1] = mk(0,  0, 32'h0,      0,  0, 32'h0,      1, 1, 10, 32'd7);
    vecs[2] = mk(1, 11, 32'd15,     1, 12, 32'hDEAD,   0, 1, 10, 32'd7);
    vecs[3] = mk(0,  0, 32'h0,      0,  0, 32'h0,      1, 1, 12, 32'hDEAD);
    vecs[4] = mk(0,  0, 32'h0,      0,  0, 32'h0,      1, 1, 11, 32'd15);
    vecs[5] = mk(0,  0, 32'h0,      0,  0, 32'h0,      0, 1, 11, 32'd15);
    vecs[6] = mk(1,  0, 32'h55,     0,  0, 32'h0,      0, 1, 11, 32'd15);
    vecs[7] = mk(1,  5, 32'h66,     0,  0, 32'h0,      0, 0,  0, 32'h0);
    vecs[8] = mk(0,  0, 32'h0,      0,  0, 32'h0,      1, 1,  5, 32'h66);
    vecs[9] = mk(0,  0, 32'h0,      0,  0, 32'h0,      0, 1,  5, 32'h66);
    for (int i = 0; i < 10; i++) begin
      am_wb_valid  = vecs[i].am_v;
      am_wb_rd     = vecs[i].am_rd;
      am_wb_data   = vecs[i].am_d;
      mem_wb_valid = vecs[i].mem_v;
      mem_wb_rd    = vecs[i].mem_rd;
      mem_wb_data  = vecs[i].mem_d;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      check($sformatf("vec%0d_we", i),        32'(wb_we),        32'(vecs[i].exp_we));
      check($sformatf("vec%0d_release", i),   32'(wb_release),   32'(vecs[i].exp_we));
      check($sformatf("vec%0d_am_ready", i),  32'(am_wb_ready),  32'd1);
      check($sformatf("vec%0d_mem_ready", i), 32'(mem_wb_ready), 32'd1);
      if (vecs[i].chk_rd) begin
        check($sformatf("vec%0d_rd", i),   32'(wb_rd), 32'(vecs[i].exp_rd));
        check($sformatf("vec%0d_data", i), wb_data,    vecs[i].exp_data);
      end
    end

    // ---------------- back-pressure with a streaming memory source ----------------
    apply_reset("bp");
    am_idx = 0;
    mseq = 0;
    first_alu_edge = -1;
    saw_stall = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (am_idx < 3) begin
        am_wb_valid = 1'b1;
        am_wb_rd    = 5'(am_idx + 1);
        am_wb_data  = 32'(100 + am_idx);
      end else begin
        am_wb_valid = 1'b0;
      end
      if (k < 16) begin
        mem_wb_valid = 1'b1;
        mem_wb_rd    = 5'(16 + (mseq % 8));
        mem_wb_data  = 32'hA000 + 32'(mseq);
      end else begin
        mem_wb_valid = 1'b0;
      end
      if (am_wb_valid && !am_wb_ready && !saw_stall) begin
        saw_stall = 1'b1;
        check("bp_ready_drop_after_two", 32'(am_idx), 32'd2);
      end
      am_acc  = am_wb_valid && am_wb_ready;
      mem_acc = mem_wb_valid && mem_wb_ready;
      cycle("bp");
      if (am_acc)  am_idx++;
      if (mem_acc) mseq++;
      if (wb_we && wb_rd >= 1 && wb_rd <= 3) begin
        am_order.push_back(int'(wb_rd));
        if (first_alu_edge < 0) first_alu_edge = k;
      end
    end
    idle_inputs();
    check("bp_saw_stall",      32'(saw_stall),        32'd1);
    check("bp_alu_win_edge",   32'(first_alu_edge),   32'd4);
    check("bp_alu_write_count", 32'(am_order.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < am_order.size()) check($sformatf("bp_order%0d", i), 32'(am_order[i]), 32'(i + 1));
      else                     check($sformatf("bp_order%0d", i), 32'hFFFF_FFFF,    32'(i + 1));
    end

    // ---------------- reset with results queued ----------------
    apply_reset("rq");
    for (int k = 0; k < 5; k++) begin
      am_wb_valid  = 1'b1;
      am_wb_rd     = 5'(6 + k);
      am_wb_data   = 32'hB000 + 32'(k);
      mem_wb_valid = 1'b1;
      mem_wb_rd    = 5'(24 + k);
      mem_wb_data  = 32'hC000 + 32'(k);
      cycle("rq_fill");
    end
    apply_reset("rq_mid");
    late_we = 0;
    for (int k = 0; k < 6; k++) begin
      cycle("rq_after");
      if (wb_we) late_we++;
    end
    check("rq_no_write_after_reset", 32'(late_we), 32'd0);

    // ---------------- randomized traffic against the model ----------------
    apply_reset("rnd");
    for (int k = 0; k < 3000; k++) begin
      if (!am_wb_valid || am_wb_ready) begin
        am_wb_valid = ($urandom_range(0, 99) < 55);
        am_wb_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        am_wb_data  = $urandom;
      end
      if (!mem_wb_valid || mem_wb_ready) begin
        mem_wb_valid = ($urandom_range(0, 99) < 65);
        mem_wb_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem_wb_data  = $urandom;
      end
      cycle("rnd");
    end
    idle_inputs();
    for (int k = 0; k < 6; k++) cycle("rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage of the i2o2 core, directly downstream of ALUMISC and the memory unit.
- Each source has its own small completion FIFO; the block arbitrates one result per cycle onto the single register-file write port.
- It also emits the release of the scoreboard pending bit consumed by the issue stage.
- Memory results have priority; a starvation counter guarantees ALU progress.

Parameters:
- XLEN, 32, data width of results and the write port.
- REGW, 5, register index width.
- DEPTH, 2, entries per source FIFO (power of two, ≥2).
- STARVE_LIMIT, 3, consecutive lost arbitrations after which ALU wins.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- am_wb_valid  in  1  ALUMISC result valid.
- am_wb_rd  in  REGW  ALUMISC destination register.
- am_wb_data  in  XLEN  ALUMISC result.
- am_wb_ready  out  1  ALU FIFO can accept; issue stage stalls ALU issue when low.
- mem_wb_valid  in  1  memory unit result valid.
- mem_wb_rd  in  REGW  memory destination register.
- mem_wb_data  in  XLEN  load data.
- mem_wb_ready  out  1  memory FIFO can accept.
- wb_we  out  1  register-file write enable.
- wb_rd  out  REGW  write index.
- wb_data  out  XLEN  write data.
- wb_release  out  1  clear scoreboard pending bit of wb_rd.

Behaviour:
- Reset (reset=0, asynchronous):
  - both FIFOs empty; starve counter 0.
  - wb_we=0, wb_release=0, wb_rd=0, wb_data=0.
  - am_wb_ready=0 and mem_wb_ready=0 while reset is low.
  - One cycle after release: both ready=1.
  - Reset mid-operation discards all queued results.
- Accept: a result is enqueued at rising edge E when valid&&ready.
  - ready = !full, driven from the registered count; no combinational path from valid to ready.
  - valid with ready=0 is ignored; the source holds it.
- FIFO: count 0..DEPTH, circular read/write pointers wrapping at DEPTH.
  - Push and pop in the same cycle leave count unchanged, including at count=DEPTH-1 and count=1.
  - A full FIFO accepts no push, so no simultaneous push/pop occurs at full.
- Arbitration (combinational on the FIFO heads, result registered at the next edge):
  - only mem non-empty → mem; only ALU non-empty → ALU.
  - both non-empty → mem, unless starve==STARVE_LIMIT, then ALU.
  - Winner is popped at the same edge that loads the output registers.
- Starve counter:
  - increments when ALU is non-empty and loses.
  - reset to 0 when ALU wins or the ALU FIFO is empty.
  - saturates at STARVE_LIMIT.
- Latency: a result accepted at edge E, with no competition, appears with wb_we=1 during the cycle after edge E+1. There is no bypass.
- Output registers:
  - wb_we=1 for exactly one cycle per popped entry with rd≠0.
  - rd=0 entries are popped with wb_we=0 and wb_release=0 (x0 is never pending).
  - wb_release always equals wb_we.
  - When nothing is popped, wb_we=0; wb_rd and wb_data hold their last values.
- Precondition (enforced by the issue-stage scoreboard, not checked here): no two in-flight results share an rd≠0.
- Throughput: one writeback per cycle sustained, with both sources streaming.

Decomposition:
- Shared package core_pkg holds:
  - XLEN and REGW.
  - Source-id encoding: SRC_AM=0, SRC_MEM=1.
  - The wb result struct/field widths (rd, data).
- One natural sub-module, wb_fifo: parameterised DEPTH/width FIFO with full/empty/count. It is instantiated once per source; arbiter and output registers live in wb_arbiter.

Test Plan:
- Reset pulse low 2 ns → wb_we=0 and both ready=0 during reset; both ready=1 one cycle after release.
- Single ALU result: am_wb_valid 1 cycle, rd=10, data=7 → wb_we=1, wb_rd=10, wb_data=7 one cycle after the accept edge, with wb_release=1 in the same cycle.
- Same-edge collision: ALU (rd=11, 15) and mem (rd=12, 0xDEAD) → mem written first, ALU the next cycle; both ready stay 1.
- Back-pressure: continuous mem stream while the ALU pushes 3 results (rd 1,2,3):
  - am_wb_ready drops after 2 are queued.
  - ALU wins after 3 lost cycles.
  - All three written in order 1,2,3 with no loss or duplication.
- x0 drop: ALU result rd=0, data=0x55 → entry consumed, wb_we=0, wb_release=0; a following rd=5 is written normally.
- Reset asserted with both FIFOs holding 2 entries → no wb_we after reset; queued entries never written.
